// File: rtl/stereo_frame_scheduler_pkg.sv
// Shared definitions for the stereo frame scheduler: FSM state encoding and
// default watchdog sizing.
package stereo_frame_scheduler_pkg;

  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_CLEAR     = 3'd1;
  localparam state_t S_START     = 3'd2;
  localparam state_t S_WAIT_DESC = 3'd3;
  localparam state_t S_MATCH     = 3'd4;
  localparam state_t S_DONE      = 3'd5;
  localparam state_t S_ERROR     = 3'd6;

  localparam int unsigned DEFAULT_TIMEOUT_W      = 24;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 10_000_000;

endpackage

// File: rtl/stereo_frame_scheduler_if.sv
// Control/status bundle between the frame scheduler and the stereo pipeline.
//   master : pipeline side (drives run/single/abort and the done indications)
//   slave  : scheduler side (drives start/clear pulses, match_enable, status)
interface stereo_frame_scheduler_if #(
  parameter int unsigned FRAME_CNT_W = 16,
  parameter int unsigned SKEW_W      = 16
);

  logic                   run;
  logic                   single;
  logic                   abort;
  logic                   l_desc_done;
  logic                   r_desc_done;
  logic                   stitch_done;

  logic                   l_start;
  logic                   r_start;
  logic                   l_clear;
  logic                   r_clear;
  logic                   match_enable;
  logic                   busy;
  logic                   frame_done;
  logic                   timeout_err;
  logic [FRAME_CNT_W-1:0] frame_count;
  logic [SKEW_W-1:0]      skew;

  modport master (
    output run, single, abort, l_desc_done, r_desc_done, stitch_done,
    input  l_start, r_start, l_clear, r_clear, match_enable, busy,
           frame_done, timeout_err, frame_count, skew
  );

  modport slave (
    input  run, single, abort, l_desc_done, r_desc_done, stitch_done,
    output l_start, r_start, l_clear, r_clear, match_enable, busy,
           frame_done, timeout_err, frame_count, skew
  );

endinterface

// File: rtl/stereo_frame_scheduler_frame_watchdog.sv
// Frame watchdog: counts enabled cycles since the last clear and flags when
// the count reaches limit-1 while still enabled.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : zero the counter (has priority over enable)
//   enable     : count this cycle
//   limit      : number of enabled cycles allowed
//   expired_c  : combinational, high in the last allowed enabled cycle
module frame_watchdog #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired_c
);

  logic [W-1:0] count_q;

  assign expired_c = enable && (count_q == limit - W'(1));

  // Counter holds once expired so it never wraps back to a quiet value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired_c) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/stereo_frame_scheduler.sv
// Frame-level sequencer for the dual-camera stitching pipeline.
// Clears and starts both capture chains, waits for both descriptor chains,
// enables matching/stitching, closes the frame on stitch_done and tracks
// frame count, left/right completion skew and a per-frame watchdog.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of stereo_frame_scheduler_if (all outputs registered)
module stereo_frame_scheduler
  import stereo_frame_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_W      = DEFAULT_TIMEOUT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned FRAME_CNT_W    = 16,
  parameter int unsigned SKEW_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  stereo_frame_scheduler_if.slave  bus
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  state_t            state_q;
  state_t            state_d;
  logic              cont_q;
  logic              l_seen_q;
  logic              r_seen_q;
  logic              l_seen_n;
  logic              r_seen_n;
  logic [SKEW_W-1:0] skew_cnt_q;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;

  logic              start_d;
  logic              clear_d;
  logic              match_enable_d;
  logic              busy_d;
  logic              frame_done_d;
  logic              timeout_err_d;

  // Seen flags including this cycle's indication, so simultaneous dones go straight to MATCH.
  assign l_seen_n  = l_seen_q | bus.l_desc_done;
  assign r_seen_n  = r_seen_q | bus.r_desc_done;

  assign wd_clear  = (state_q == S_START);
  assign wd_enable = (state_q == S_WAIT_DESC) || (state_q == S_MATCH);

  frame_watchdog #(
    .W (TIMEOUT_W)
  ) u_frame_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (wd_clear),
    .enable    (wd_enable),
    .limit     (TIMEOUT_LIMIT),
    .expired_c (wd_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.run || bus.single) state_d = S_CLEAR;
      S_CLEAR:     state_d = S_START;
      S_START:     state_d = S_WAIT_DESC;
      S_WAIT_DESC: begin
        if (l_seen_n && r_seen_n) state_d = S_MATCH;
        else if (wd_expired)      state_d = S_ERROR;
      end
      S_MATCH: begin
        // A frame finishing on the expiry cycle still counts as completed.
        if (bus.stitch_done)  state_d = S_DONE;
        else if (wd_expired)  state_d = S_ERROR;
      end
      S_DONE:      state_d = (cont_q && bus.run) ? S_CLEAR : S_IDLE;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_IDLE;
    endcase
    if (bus.abort) state_d = S_IDLE;
  end

  // Output decode from the next state so registered outputs align with state_q.
  always_comb begin
    start_d        = 1'b0;
    clear_d        = 1'b0;
    match_enable_d = 1'b0;
    busy_d         = 1'b0;
    frame_done_d   = 1'b0;
    timeout_err_d  = 1'b0;
    case (state_d)
      S_CLEAR:     begin clear_d = 1'b1;        busy_d = 1'b1; end
      S_START:     begin start_d = 1'b1;        busy_d = 1'b1; end
      S_WAIT_DESC: begin                        busy_d = 1'b1; end
      S_MATCH:     begin match_enable_d = 1'b1; busy_d = 1'b1; end
      S_DONE:      begin frame_done_d = 1'b1;   busy_d = 1'b1; end
      S_ERROR:     begin timeout_err_d = 1'b1; end
      default:     ;
    endcase
  end

  // Frame mode latch, descriptor seen flags and skew measurement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cont_q     <= 1'b0;
      l_seen_q   <= 1'b0;
      r_seen_q   <= 1'b0;
      skew_cnt_q <= '0;
    end else if (bus.abort) begin
      l_seen_q   <= 1'b0;
      r_seen_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && state_d == S_CLEAR) cont_q <= bus.run;
      if (state_q == S_START) begin
        l_seen_q   <= 1'b0;
        r_seen_q   <= 1'b0;
        skew_cnt_q <= '0;
      end
      if (state_q == S_WAIT_DESC) begin
        l_seen_q <= l_seen_n;
        r_seen_q <= r_seen_n;
        // Exactly one side finished: the other side is lagging this cycle.
        if ((l_seen_q ^ r_seen_q) && (skew_cnt_q != '1)) begin
          skew_cnt_q <= skew_cnt_q + SKEW_W'(1);
        end
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.l_start      <= 1'b0;
      bus.r_start      <= 1'b0;
      bus.l_clear      <= 1'b0;
      bus.r_clear      <= 1'b0;
      bus.match_enable <= 1'b0;
      bus.busy         <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.frame_count  <= '0;
      bus.skew         <= '0;
    end else begin
      bus.l_start      <= start_d;
      bus.r_start      <= start_d;
      bus.l_clear      <= clear_d;
      bus.r_clear      <= clear_d;
      bus.match_enable <= match_enable_d;
      bus.busy         <= busy_d;
      bus.frame_done   <= frame_done_d;
      bus.timeout_err  <= timeout_err_d;
      if (frame_done_d) begin
        bus.frame_count <= bus.frame_count + FRAME_CNT_W'(1);
        bus.skew        <= skew_cnt_q;
      end
    end
  end

endmodule
